// File: rtl/shift_register_receiver_if.sv
// Serial receiver port bundle: bit-stream inputs, held-word handshake and status outputs.
interface shift_register_receiver_if #(
  parameter int unsigned WIDTH = 4
);
  logic                     ShiftEnable;
  logic                     ShiftInput;
  logic                     Direction;
  logic                     Clear;
  logic                     DataAck;
  logic [WIDTH-1:0]         dataBus;
  logic                     DataValid;
  logic                     Busy;
  logic [$clog2(WIDTH)-1:0] BitCount;
  logic                     Overrun;

  modport master (
    output ShiftEnable, ShiftInput, Direction, Clear, DataAck,
    input  dataBus, DataValid, Busy, BitCount, Overrun
  );

  modport slave (
    input  ShiftEnable, ShiftInput, Direction, Clear, DataAck,
    output dataBus, DataValid, Busy, BitCount, Overrun
  );
endinterface

// File: rtl/shift_register_receiver.sv
// Serial-to-parallel receiver: assembles WIDTH-bit frames MSB- or LSB-first and holds the last
// completed word behind a valid/ack handshake with sticky overrun reporting.
module shift_register_receiver #(
  parameter int unsigned WIDTH = 4
) (
  input logic                      clockPulse,
  input logic                      Reset,
  shift_register_receiver_if.slave bus
);
  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCount = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StRecv} state_e;

  state_e           stateQ, stateD;
  logic [WIDTH-1:0] shregQ, shregD;
  logic [CntW-1:0]  countQ, countD;
  logic             dirQ, dirD;
  logic [WIDTH-1:0] dataQ, dataD;
  logic             validQ, validD;
  logic             overrunQ, overrunD;

  logic             dirEff;
  logic [WIDTH-1:0] newWord;
  logic             complete;

  always_comb begin
    stateD   = stateQ;
    shregD   = shregQ;
    countD   = countQ;
    dirD     = dirQ;
    dataD    = dataQ;
    validD   = validQ;
    overrunD = overrunQ;
    complete = 1'b0;

    // Direction is sampled only on the first bit of a frame.
    dirEff  = (stateQ == StIdle) ? bus.Direction : dirQ;
    newWord = dirEff ? {bus.ShiftInput, shregQ[WIDTH-1:1]}
                     : {shregQ[WIDTH-2:0], bus.ShiftInput};

    if (bus.Clear) begin
      stateD   = StIdle;
      shregD   = '0;
      countD   = '0;
      validD   = 1'b0;
      overrunD = 1'b0;
    end else begin
      if (bus.ShiftEnable) begin
        dirD = dirEff;
        if (countQ == LastCount) begin
          complete = 1'b1;
          stateD   = StIdle;
          shregD   = '0;
          countD   = '0;
          if (!validQ || bus.DataAck) begin
            dataD  = newWord;
            validD = 1'b1;
          end else begin
            overrunD = 1'b1;
          end
        end else begin
          stateD = StRecv;
          shregD = newWord;
          countD = countQ + CntW'(1);
        end
      end
      if (!complete && bus.DataAck && validQ) begin
        validD = 1'b0;
      end
    end
  end

  always_ff @(posedge clockPulse or negedge Reset) begin
    if (!Reset) begin
      stateQ   <= StIdle;
      shregQ   <= '0;
      countQ   <= '0;
      dirQ     <= 1'b0;
      dataQ    <= '0;
      validQ   <= 1'b0;
      overrunQ <= 1'b0;
    end else begin
      stateQ   <= stateD;
      shregQ   <= shregD;
      countQ   <= countD;
      dirQ     <= dirD;
      dataQ    <= dataD;
      validQ   <= validD;
      overrunQ <= overrunD;
    end
  end

  assign bus.dataBus   = dataQ;
  assign bus.DataValid = validQ;
  assign bus.Busy      = (stateQ == StRecv);
  assign bus.BitCount  = countQ;
  assign bus.Overrun   = overrunQ;
endmodule

// File: tb/tb_shift_register_receiver.sv
// Scoreboard bench for shift_register_receiver at WIDTH=4.
module tb_shift_register_receiver;
  localparam int unsigned W = 4;

  logic clockPulse = 1'b0;
  logic Reset      = 1'b0;
  int   checks     = 0;
  int   errors     = 0;
  logic [W-1:0] expQ[$];

  shift_register_receiver_if #(.WIDTH(W)) bus ();

  shift_register_receiver #(.WIDTH(W)) dut (
    .clockPulse(clockPulse),
    .Reset     (Reset),
    .bus       (bus.slave)
  );

  always #5 clockPulse = ~clockPulse;

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference assembly: bits[W-1] is sent first.
  function automatic logic [W-1:0] modelWord(input logic [W-1:0] bits, input logic dir);
    logic [W-1:0] w;
    if (!dir) return bits;
    for (int i = 0; i < W; i++) w[i] = bits[W-1-i];
    return w;
  endfunction

  task automatic pushBit(input logic b, input logic dir, input logic ack);
    @(negedge clockPulse);
    bus.ShiftEnable = 1'b1;
    bus.ShiftInput  = b;
    bus.Direction   = dir;
    bus.DataAck     = ack;
    @(posedge clockPulse);
    #1;
    bus.ShiftEnable = 1'b0;
    bus.DataAck     = 1'b0;
  endtask

  task automatic idleCycle();
    @(negedge clockPulse);
    @(posedge clockPulse);
    #1;
  endtask

  task automatic sendFrame(input logic [W-1:0] bits, input logic dir, input int flipAt,
                           input bit accept, input bit ackLast, input int gap);
    logic d;
    if (accept) expQ.push_back(modelWord(bits, dir));
    for (int i = 0; i < W; i++) begin
      d = (flipAt >= 0 && i >= flipAt) ? ~dir : dir;
      pushBit(bits[W-1-i], d, ackLast && (i == W - 1));
      if (i < W - 1) begin
        checkValue("midCount", 32'(bus.BitCount), 32'(i + 1));
        checkValue("midBusy", 32'(bus.Busy), 32'd1);
        for (int g = 0; g < gap; g++) begin
          idleCycle();
          checkValue("gapCount", 32'(bus.BitCount), 32'(i + 1));
        end
      end
    end
    checkValue("endBusy", 32'(bus.Busy), 32'd0);
    checkValue("endCount", 32'(bus.BitCount), 32'd0);
    checkValue("endValid", 32'(bus.DataValid), 32'd1);
    if (accept) begin
      if (expQ.size() == 0) begin
        checkValue("scoreboardEmpty", 32'd0, 32'd1);
      end else begin
        checkValue("word", 32'(bus.dataBus), 32'(expQ.pop_front()));
      end
    end
  endtask

  task automatic ackWord(input logic [W-1:0] held);
    @(negedge clockPulse);
    bus.DataAck = 1'b1;
    @(posedge clockPulse);
    #1;
    bus.DataAck = 1'b0;
    checkValue("ackValid", 32'(bus.DataValid), 32'd0);
    checkValue("ackData", 32'(bus.dataBus), 32'(held));
  endtask

  task automatic checkResetState(input string tag);
    checkValue({tag, "Data"}, 32'(bus.dataBus), 32'd0);
    checkValue({tag, "Valid"}, 32'(bus.DataValid), 32'd0);
    checkValue({tag, "Busy"}, 32'(bus.Busy), 32'd0);
    checkValue({tag, "Count"}, 32'(bus.BitCount), 32'd0);
    checkValue({tag, "Overrun"}, 32'(bus.Overrun), 32'd0);
  endtask

  initial begin
    bus.ShiftEnable = 1'b0;
    bus.ShiftInput  = 1'b0;
    bus.Direction   = 1'b0;
    bus.Clear       = 1'b0;
    bus.DataAck     = 1'b0;
    #12;
    checkResetState("rst");
    Reset = 1'b1;

    // MSB-first, then ack
    sendFrame(4'b1010, 1'b0, -1, 1'b1, 1'b0, 0);
    ackWord(4'b1010);

    // Ack while nothing is held is ignored
    ackWord(4'b1010);

    // LSB-first, and with Direction flipped mid-frame
    sendFrame(4'b0101, 1'b1, -1, 1'b1, 1'b0, 0);
    ackWord(4'b1010);
    sendFrame(4'b0101, 1'b1, 2, 1'b1, 1'b0, 0);

    // Overrun: 1010 held, 1111 dropped
    sendFrame(4'b1111, 1'b0, -1, 1'b0, 1'b0, 0);
    checkValue("ovrData", 32'(bus.dataBus), 32'hA);
    checkValue("ovrFlag", 32'(bus.Overrun), 32'd1);
    @(negedge clockPulse);
    bus.Clear = 1'b1;
    @(posedge clockPulse);
    #1;
    bus.Clear = 1'b0;
    checkValue("clrOverrun", 32'(bus.Overrun), 32'd0);
    checkValue("clrValid", 32'(bus.DataValid), 32'd0);
    checkValue("clrData", 32'(bus.dataBus), 32'hA);

    // Back-to-back frames with ack on the completing edge
    sendFrame(4'b1010, 1'b0, -1, 1'b1, 1'b0, 0);
    sendFrame(4'b0110, 1'b0, -1, 1'b1, 1'b1, 0);
    checkValue("ackCollOverrun", 32'(bus.Overrun), 32'd0);
    ackWord(4'b0110);

    // Clear mid-frame discards the partial frame and the bit at that edge
    pushBit(1'b1, 1'b0, 1'b0);
    @(negedge clockPulse);
    bus.Clear       = 1'b1;
    bus.ShiftEnable = 1'b1;
    bus.ShiftInput  = 1'b1;
    @(posedge clockPulse);
    #1;
    bus.Clear       = 1'b0;
    bus.ShiftEnable = 1'b0;
    checkValue("midClrCount", 32'(bus.BitCount), 32'd0);
    checkValue("midClrBusy", 32'(bus.Busy), 32'd0);
    sendFrame(4'b1001, 1'b0, -1, 1'b1, 1'b0, 0);

    // Asynchronous reset after two bits
    pushBit(1'b1, 1'b0, 1'b0);
    pushBit(1'b1, 1'b0, 1'b0);
    #2;
    Reset = 1'b0;
    #1;
    checkResetState("async");
    #2;
    Reset = 1'b1;
    sendFrame(4'b0011, 1'b0, -1, 1'b1, 1'b0, 0);
    ackWord(4'b0011);

    // Gaps of idle cycles between bits
    sendFrame(4'b1100, 1'b0, -1, 1'b1, 1'b0, 3);

    checkValue("scoreboardDrained", 32'(expQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
